// File: rtl/fifo_level.sv
// fifo_level -- synchronous FIFO with an occupancy count and programmable
// almost-full / almost-empty thresholds. The read port is show-ahead, so the
// head word is always on rdata.
//
// Optional feature macro: FIFO_ERR_EN adds the sticky overflow/underflow flags
// and their err_clr input. Without it, rejected requests are silently dropped.
//
// Parameters:
//   B       data width
//   W       address width, depth D = 2**W
//   AF_LVL  almost_full  when count >= AF_LVL
//   AE_LVL  almost_empty when count <= AE_LVL   (0 <= AE_LVL < AF_LVL <= D)
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   wr, wdata             write request and data
//   rd                    pop request
//   rdata                 head-of-queue word (don't-care while empty)
//   empty, full           count == 0 / count == D
//   almost_empty/full     threshold flags
//   count                 occupancy 0..D
//   overflow, underflow   sticky error flags       (FIFO_ERR_EN only)
//   err_clr               synchronous flag clear   (FIFO_ERR_EN only)

// One storage word. Not reset: contents are only observable once written.
module fifo_level_cell #(
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         we,
  input  logic [B-1:0] d,
  output logic [B-1:0] q
);
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end
endmodule

module fifo_level #(
  parameter int B      = 8,
  parameter int W      = 4,
  parameter int AF_LVL = 2**W - 2,
  parameter int AE_LVL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  input  logic [B-1:0] wdata,
  output logic [B-1:0] rdata,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count
`ifdef FIFO_ERR_EN
  ,
  input  logic         err_clr,
  output logic         overflow,
  output logic         underflow
`endif
);

  localparam int         D     = 2**W;
  localparam logic [W:0] DEPTH = {1'b1, {W{1'b0}}};
  localparam logic [W:0] AF    = AF_LVL[W:0];
  localparam logic [W:0] AE    = AE_LVL[W:0];

  logic [W-1:0]        wp, rp;
  logic [W:0]          count_next;
  logic                wacc, racc;
  logic [D-1:0][B-1:0] mem;

  // Writing into a full FIFO is fine when the same edge pops the head:
  // the freed slot is the one the write pointer already points at.
  assign wacc = wr & (~full | rd);
  assign racc = rd & ~empty;

  assign count_next = count + {{W{1'b0}}, wacc} - {{W{1'b0}}, racc};

  // Storage array, one cell per slot.
  for (genvar i = 0; i < D; i++) begin : g_cell
    fifo_level_cell #(.B(B)) u_cell (
      .clk (clk),
      .we  (wacc && (wp == W'(i))),
      .d   (wdata),
      .q   (mem[i])
    );
  end

  // Show-ahead read: head word straight from the array.
  assign rdata = mem[rp];

  // Pointers wrap modulo D by natural overflow of W bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wacc) wp <= wp + 1'b1;
      if (racc) rp <= rp + 1'b1;
    end
  end

  // Count and flags are registered from count_next so every flag is exact
  // in the cycle following the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == DEPTH);
      almost_empty <= (count_next <= AE);
      almost_full  <= (count_next >= AF);
    end
  end

`ifdef FIFO_ERR_EN
  // Sticky error flags; a set on the same edge as err_clr wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~err_clr) | (wr & ~wacc);
      underflow <= (underflow & ~err_clr) | (rd & empty);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_level.sv
module tb_fifo_level;
  localparam int B  = 8;
  localparam int W  = 2;
  localparam int D  = 4;
  localparam int AF = 2;
  localparam int AE = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr = 1'b0, rd = 1'b0, err_clr = 1'b0;
  logic [B-1:0] wdata = '0;
  logic [B-1:0] rdata;
  logic         empty, full, almost_empty, almost_full;
  logic [W:0]   count;
  logic         overflow, underflow;

  int vectors = 0;
  int errs    = 0;

  fifo_level #(.B(B), .W(W), .AF_LVL(AF), .AE_LVL(AE)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .wdata        (wdata),
    .rdata        (rdata),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count)
`ifdef FIFO_ERR_EN
    ,
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

`ifndef FIFO_ERR_EN
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a queue of words plus two sticky bits.
  logic [B-1:0] mq[$];
  bit           m_ovf, m_unf;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      bit wa, ra;
      ra = rd && (mq.size() > 0);
      wa = wr && ((mq.size() < D) || rd);
      if (wr && !wa) m_ovf = 1; else if (err_clr) m_ovf = 0;
      if (rd && mq.size() == 0) m_unf = 1; else if (err_clr) m_unf = 0;
      if (ra) void'(mq.pop_front());
      if (wa) mq.push_back(wdata);
    end
  end

  // Single compare process: every falling edge, DUT vs model.
  always @(negedge clk) begin
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_empty", 32'(empty), 32'(mq.size() == 0));
    chk("m_full",  32'(full),  32'(mq.size() == D));
    chk("m_aempty", 32'(almost_empty), 32'(mq.size() <= AE));
    chk("m_afull",  32'(almost_full),  32'(mq.size() >= AF));
    if (mq.size() > 0) chk("m_rdata", 32'(rdata), 32'(mq[0]));
`ifdef FIFO_ERR_EN
    chk("m_overflow",  32'(overflow),  32'(m_ovf));
    chk("m_underflow", 32'(underflow), 32'(m_unf));
`endif
  end

  // Drive one cycle's inputs, then land 1 time unit after the next falling edge.
  task automatic step(input logic w, input logic r, input logic [B-1:0] d, input logic c);
    wr = w; rd = r; wdata = d; err_clr = c;
    @(negedge clk); #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_afull", 32'(almost_full), 0);
`ifdef FIFO_ERR_EN
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
`endif
  endtask

  initial begin
    logic [B-1:0] seq4 [4];
    seq4 = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset held for two cycles.
    @(negedge clk); #1;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Fill: 0x11..0x44.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, seq4[i], 0);
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 2));
      chk("fill_full",  32'(full), 32'(i == 3));
      chk("fill_rdata", 32'(rdata), 32'h11);
    end

    // Write into full without read: rejected.
    step(1, 0, 8'h55, 0);
    chk("ovf_count", 32'(count), 4);
    chk("ovf_rdata", 32'(rdata), 32'h11);
`ifdef FIFO_ERR_EN
    chk("ovf_flag", 32'(overflow), 1);
    step(0, 0, 8'h00, 1);
    chk("ovf_clr", 32'(overflow), 0);
`endif

    // Write + read while full.
    chk("wr_rd_full_head", 32'(rdata), 32'h11);
    step(1, 1, 8'h55, 0);
    chk("wr_rd_full_rdata", 32'(rdata), 32'h22);
    chk("wr_rd_full_count", 32'(count), 4);

    // Drain: 0x22,0x33,0x44,0x55.
    for (int i = 0; i < 4; i++) begin
      logic [B-1:0] e;
      e = (i == 3) ? 8'h55 : seq4[i + 1];
      chk("drain_rdata", 32'(rdata), 32'(e));
      step(0, 1, 8'h00, 0);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_count", 32'(count), 0);

    // Write + read while empty.
    step(1, 1, 8'hA5, 0);
    chk("wr_rd_empty_count", 32'(count), 1);
    chk("wr_rd_empty_rdata", 32'(rdata), 32'hA5);
`ifdef FIFO_ERR_EN
    chk("unf_flag", 32'(underflow), 1);
    step(0, 0, 8'h00, 1);
    chk("unf_clr", 32'(underflow), 0);
`endif
    step(0, 1, 8'h00, 0);   // pop 0xA5
    chk("pop_a5_empty", 32'(empty), 1);
`ifdef FIFO_ERR_EN
    step(0, 1, 8'h00, 1);   // clear and new underflow together
    chk("unf_set_wins", 32'(underflow), 1);
    step(0, 0, 8'h00, 1);
    chk("unf_clr2", 32'(underflow), 0);
`endif

    // Interleaved writes/reads, pointers wrap.
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 8'(8'h60 + i), 0);
      chk("wrap_rdata", 32'(rdata), 32'(8'h60 + i));
      step(0, 1, 8'h00, 0);
    end
    chk("wrap_empty", 32'(empty), 1);
    chk("wrap_count", 32'(count), 0);

    // Async reset mid-burst at count 3.
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h30 + i), 0);
    chk("burst_count", 32'(count), 3);
    wr = 1'b1; wdata = 8'h99;
    #1 reset = 1'b1;
    #1 chk_reset_vals();
    reset = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_rdata", 32'(rdata), 32'h99);
    chk("post_rst_count", 32'(count), 1);
    step(0, 0, 8'h00, 0);

    // Randomized phases with varying write/read bias.
    for (int ph = 0; ph < 6; ph++) begin
      int pw, pr;
      pw = (ph % 3 == 0) ? 75 : (ph % 3 == 1) ? 30 : 50;
      pr = 100 - pw;
      for (int c = 0; c < 400; c++) begin
        wr      = ($urandom_range(99) < pw);
        rd      = ($urandom_range(99) < pr);
        wdata   = 8'($urandom);
        err_clr = ($urandom_range(99) < 8);
        if ($urandom_range(199) == 0) begin
          #2 reset = 1'b1;
          #1 reset = 1'b0;
        end
        @(negedge clk);
      end
    end

    wr = 0; rd = 0; err_clr = 0;
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
